// File: rtl/mips_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : mips_cpu
//  Purpose  : Small multicycle MIPS-subset CPU with an internal unified
//             word memory. After reset it is a bus slave that accepts
//             program words and a RUN command. While running, stores
//             beyond internal memory become bus-master write transfers.
//  Ports    : clk          - system clock, rising edge
//             reset_ext    - asynchronous active-low reset
//             bus_ctrl_in  - command from the current bus master
//             bus_ack      - slave: transfer valid / master: grant
//             bus_data_in  - bus data into the CPU
//             bus_req      - request for bus mastership
//             bus_ctrl_out - command driven while master
//             bus_data_out - bus data out of the CPU
//  Revision : 1.0 - initial release
// ============================================================================
module mips_cpu #(
    parameter int BUS_WIDTH  = 32,
    parameter int CTRL_WIDTH = 8,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset_ext,
    input  logic [CTRL_WIDTH-1:0] bus_ctrl_in,
    input  logic                  bus_ack,
    input  logic [BUS_WIDTH-1:0]  bus_data_in,
    output logic                  bus_req,
    output logic [CTRL_WIDTH-1:0] bus_ctrl_out,
    output logic [BUS_WIDTH-1:0]  bus_data_out
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [CTRL_WIDTH-1:0] c_CMD_NONE  = CTRL_WIDTH'('hFF);
    localparam logic [CTRL_WIDTH-1:0] c_CMD_WRITE = CTRL_WIDTH'('hFE);
    localparam logic [CTRL_WIDTH-1:0] c_CMD_RUN   = CTRL_WIDTH'('hFD);

    localparam logic [BUS_WIDTH-1:0] c_MEM_WORDS_W = BUS_WIDTH'(MEM_WORDS);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_SLAVE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_XSTORE, S_HALT
    } state_e;

    typedef enum logic [1:0] {PH_ADDR, PH_DATA, PH_DONE} slv_ph_e;
    typedef enum logic [1:0] {XS_WAIT, XS_ADDR, XS_DATA} xs_ph_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q,    state_d;
    slv_ph_e                slv_ph_q,   slv_ph_d;
    xs_ph_e                 xs_ph_q,    xs_ph_d;
    logic [AW-1:0]          slv_addr_q, slv_addr_d;
    logic [BUS_WIDTH-1:0]   pc_q,       pc_d;
    logic [BUS_WIDTH-1:0]   ir_q,       ir_d;
    logic [BUS_WIDTH-1:0]   a_q,        a_d;
    logic [BUS_WIDTH-1:0]   b_q,        b_d;
    logic [BUS_WIDTH-1:0]   imm_q,      imm_d;
    logic [BUS_WIDTH-1:0]   alu_q,      alu_d;
    logic [BUS_WIDTH-1:0]   mdr_q,      mdr_d;
    logic                   req_q,      req_d;
    logic [CTRL_WIDTH-1:0]  ctrl_q,     ctrl_d;
    logic [BUS_WIDTH-1:0]   dout_q,     dout_d;

    logic [BUS_WIDTH-1:0]   rf_q  [32];
    logic [BUS_WIDTH-1:0]   mem_q [MEM_WORDS];

    // Register-file and memory write ports
    logic                   rf_we;
    logic [4:0]             rf_waddr;
    logic [BUS_WIDTH-1:0]   rf_wdata;
    logic                   mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [BUS_WIDTH-1:0]   mem_wdata;

    // ------------------------------------------------------------------
    // Instruction fields and datapath helpers
    // ------------------------------------------------------------------
    logic [5:0]             w_op;
    logic [5:0]             w_funct;
    logic [4:0]             w_rs;
    logic [4:0]             w_rt;
    logic [4:0]             w_rd;
    logic [BUS_WIDTH-1:0]   w_rs_val;
    logic [BUS_WIDTH-1:0]   w_rt_val;
    logic [BUS_WIDTH-1:0]   w_pc_plus4;
    logic [BUS_WIDTH-1:0]   w_alu_res;
    logic                   w_funct_ok;
    logic                   w_in_mem;

    assign w_op       = ir_q[31:26];
    assign w_funct    = ir_q[5:0];
    assign w_rs       = ir_q[25:21];
    assign w_rt       = ir_q[20:16];
    assign w_rd       = ir_q[15:11];
    assign w_rs_val   = (w_rs == 5'd0) ? '0 : rf_q[w_rs];
    assign w_rt_val   = (w_rt == 5'd0) ? '0 : rf_q[w_rt];
    assign w_pc_plus4 = pc_q + BUS_WIDTH'(4);

    // Effective address is internal when its word index fits the memory
    assign w_in_mem = ({2'b00, alu_q[BUS_WIDTH-1:2]} < c_MEM_WORDS_W);

    always_comb begin
        w_alu_res  = '0;
        w_funct_ok = 1'b1;
        case (w_funct)
            c_FN_ADD: w_alu_res = a_q + b_q;
            c_FN_SUB: w_alu_res = a_q - b_q;
            c_FN_AND: w_alu_res = a_q & b_q;
            c_FN_OR:  w_alu_res = a_q | b_q;
            c_FN_SLT: w_alu_res = {{(BUS_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default:  w_funct_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        slv_ph_d   = slv_ph_q;
        xs_ph_d    = xs_ph_q;
        slv_addr_d = slv_addr_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
        req_d      = req_q;
        ctrl_d     = ctrl_q;
        dout_d     = dout_q;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;

        case (state_q)
            S_SLAVE: begin
                if (!bus_ack) begin
                    slv_ph_d = PH_ADDR;
                end else if (bus_ctrl_in == c_CMD_RUN) begin
                    state_d  = S_FETCH;
                    pc_d     = '0;
                    slv_ph_d = PH_ADDR;
                end else if (bus_ctrl_in == c_CMD_WRITE) begin
                    // One word per ack burst; DONE swallows the rest of it
                    case (slv_ph_q)
                        PH_ADDR: begin
                            slv_addr_d = bus_data_in[AW-1:0];
                            slv_ph_d   = PH_DATA;
                        end
                        PH_DATA: begin
                            mem_we    = 1'b1;
                            mem_waddr = slv_addr_q;
                            mem_wdata = bus_data_in;
                            slv_ph_d  = PH_DONE;
                        end
                        default: ;
                    endcase
                end
            end

            S_FETCH: begin
                ir_d    = mem_q[pc_q[AW+1:2]];
                state_d = S_DECODE;
            end

            S_DECODE: begin
                a_d     = w_rs_val;
                b_d     = w_rt_val;
                imm_d   = {{(BUS_WIDTH-16){ir_q[15]}}, ir_q[15:0]};
                state_d = S_EXEC;
            end

            S_EXEC: begin
                case (w_op)
                    c_OP_RTYPE: begin
                        alu_d   = w_alu_res;
                        state_d = w_funct_ok ? S_WB : S_HALT;
                    end
                    c_OP_ADDI: begin
                        alu_d   = a_q + imm_q;
                        state_d = S_WB;
                    end
                    c_OP_LW, c_OP_SW: begin
                        alu_d   = a_q + imm_q;
                        state_d = S_MEM;
                    end
                    c_OP_BEQ: begin
                        pc_d    = (a_q == b_q) ? (w_pc_plus4 + (imm_q << 2)) : w_pc_plus4;
                        state_d = S_FETCH;
                    end
                    c_OP_J: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        state_d = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end

            S_MEM: begin
                if (w_op == c_OP_LW) begin
                    // Loads from outside internal memory return zero
                    mdr_d   = w_in_mem ? mem_q[alu_q[AW+1:2]] : '0;
                    state_d = S_WB;
                end else if (w_in_mem) begin
                    mem_we    = 1'b1;
                    mem_waddr = alu_q[AW+1:2];
                    mem_wdata = b_q;
                    pc_d      = w_pc_plus4;
                    state_d   = S_FETCH;
                end else begin
                    req_d   = 1'b1;
                    xs_ph_d = XS_WAIT;
                    state_d = S_XSTORE;
                end
            end

            S_WB: begin
                rf_waddr = (w_op == c_OP_RTYPE) ? w_rd : w_rt;
                rf_wdata = (w_op == c_OP_LW) ? mdr_q : alu_q;
                rf_we    = (rf_waddr != 5'd0);
                pc_d     = w_pc_plus4;
                state_d  = S_FETCH;
            end

            S_XSTORE: begin
                // Once granted, the transfer runs to completion even if
                // the grant is withdrawn part way through.
                case (xs_ph_q)
                    XS_WAIT: begin
                        if (bus_ack) begin
                            ctrl_d  = c_CMD_WRITE;
                            dout_d  = alu_q;
                            xs_ph_d = XS_ADDR;
                        end
                    end
                    XS_ADDR: begin
                        dout_d  = b_q;
                        xs_ph_d = XS_DATA;
                    end
                    default: begin
                        req_d   = 1'b0;
                        ctrl_d  = c_CMD_NONE;
                        dout_d  = '0;
                        xs_ph_d = XS_WAIT;
                        pc_d    = w_pc_plus4;
                        state_d = S_FETCH;
                    end
                endcase
            end

            default: ; // S_HALT: wait for reset
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_ext) begin
        if (!reset_ext) begin
            state_q    <= S_SLAVE;
            slv_ph_q   <= PH_ADDR;
            xs_ph_q    <= XS_WAIT;
            slv_addr_q <= '0;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            alu_q      <= '0;
            mdr_q      <= '0;
            req_q      <= 1'b0;
            ctrl_q     <= c_CMD_NONE;
            dout_q     <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            slv_ph_q   <= slv_ph_d;
            xs_ph_q    <= xs_ph_d;
            slv_addr_q <= slv_addr_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            alu_q      <= alu_d;
            mdr_q      <= mdr_d;
            req_q      <= req_d;
            ctrl_q     <= ctrl_d;
            dout_q     <= dout_d;
            if (rf_we) begin
                rf_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    // Memory survives reset so a loaded program can be re-run
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus_req      = req_q;
    assign bus_ctrl_out = ctrl_q;
    assign bus_data_out = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_cpu
//  Purpose  : Self-checking bench for mips_cpu. Acts as bus master to load
//             programs and as arbiter to grant external stores; expected
//             stores are queued per program and compared as they appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu;

    localparam logic [7:0]  CMD_NONE  = 8'hFF;
    localparam logic [7:0]  CMD_WRITE = 8'hFE;
    localparam logic [7:0]  CMD_RUN   = 8'hFD;
    localparam logic [31:0] HALT_I    = 32'hFC000000;
    localparam logic [31:0] NOP_I     = 32'h00000020;   // add $0,$0,$0

    logic        clk         = 1'b0;
    logic        reset_ext   = 1'b0;
    logic [7:0]  bus_ctrl_in = CMD_NONE;
    logic        bus_ack     = 1'b0;
    logic [31:0] bus_data_in = '0;
    logic        bus_req;
    logic [7:0]  bus_ctrl_out;
    logic [31:0] bus_data_out;

    mips_cpu #(
        .BUS_WIDTH (32),
        .CTRL_WIDTH(8),
        .MEM_WORDS (256)
    ) dut (
        .clk         (clk),
        .reset_ext   (reset_ext),
        .bus_ctrl_in (bus_ctrl_in),
        .bus_ack     (bus_ack),
        .bus_data_in (bus_data_in),
        .bus_req     (bus_req),
        .bus_ctrl_out(bus_ctrl_out),
        .bus_data_out(bus_data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct packed {
        logic [31:0] i0;
        logic [31:0] i1;
        logic [31:0] exp;
    } alu_vec_t;

    xfer_t       exp_q[$];
    logic [31:0] prog_q[$];
    alu_vec_t    vecs[9];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.addr = a;
        x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        bus_ack     = 1'b0;
        bus_ctrl_in = CMD_NONE;
        bus_data_in = '0;
        reset_ext   = 1'b0;
        repeat (3) @(negedge clk);
        reset_ext = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_ack = 1'b1; bus_ctrl_in = CMD_WRITE; bus_data_in = addr;
        @(negedge clk);
        bus_data_in = data;
        @(negedge clk);
        bus_ack = 1'b0; bus_ctrl_in = CMD_NONE; bus_data_in = '0;
    endtask

    task automatic load_prog();
        for (int k = 0; k < prog_q.size(); k++) begin
            load_word(32'(k), prog_q[k]);
        end
    endtask

    task automatic run_cmd();
        @(negedge clk);
        bus_ack = 1'b1; bus_ctrl_in = CMD_RUN;
        @(negedge clk);
        bus_ack = 1'b0; bus_ctrl_in = CMD_NONE;
    endtask

    // Grants every bus request within the budget and checks the transfer
    // against the head of the expected-store queue.
    task automatic serve(input string tag, input int budget, input bit drop_ack);
        int    cyc;
        xfer_t got;
        xfer_t want;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus_req === 1'b1) begin
                bus_ack = 1'b1;
                @(negedge clk);
                check({tag, "_ctrl_addr"}, 32'(bus_ctrl_out), 32'(CMD_WRITE));
                got.addr = bus_data_out;
                if (drop_ack) bus_ack = 1'b0;
                @(negedge clk);
                check({tag, "_ctrl_data"}, 32'(bus_ctrl_out), 32'(CMD_WRITE));
                check({tag, "_req_held"}, 32'(bus_req), 32'h1);
                got.data = bus_data_out;
                bus_ack = 1'b0;
                @(negedge clk);
                check({tag, "_req_rel"}, 32'(bus_req), 32'h0);
                check({tag, "_ctrl_idle"}, 32'(bus_ctrl_out), 32'(CMD_NONE));
                check({tag, "_data_idle"}, bus_data_out, 32'h0);
                cyc += 3;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s_unexpected: got store 0x%08h <= 0x%08h, expected none",
                             tag, got.addr, got.data);
                end else begin
                    want = exp_q.pop_front();
                    check({tag, "_addr"}, got.addr, want.addr);
                    check({tag, "_data"}, got.data, want.data);
                end
            end
        end
        check({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic run_prog(input string tag, input bit drop_ack);
        do_reset();
        load_prog();
        run_cmd();
        serve(tag, 300, drop_ack);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int waited;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_req", 32'(bus_req), 32'h0);
        check("rst_ctrl", 32'(bus_ctrl_out), 32'(CMD_NONE));
        check("rst_data", bus_data_out, 32'h0);

        // ---------------- load / run, external store ----------------
        prog_q = '{32'h20080005, 32'h201D1050, 32'hAFA80000, HALT_I};
        expect_store(32'h00001050, 32'h00000005);
        run_prog("ext", 1'b1);

        // ---------------- ALU table ----------------
        // template: addi $1,$0,5; addi $2,$0,-1; i0; i1; sw $3,0x400($0); halt
        vecs[0] = '{NOP_I,        32'h00221820, 32'h00000004};  // add
        vecs[1] = '{NOP_I,        32'h00221822, 32'h00000006};  // sub
        vecs[2] = '{NOP_I,        32'h00221824, 32'h00000005};  // and
        vecs[3] = '{NOP_I,        32'h00221825, 32'hFFFFFFFF};  // or
        vecs[4] = '{32'h20030007, 32'h0022182A, 32'h00000000};  // slt 5<-1
        vecs[5] = '{NOP_I,        32'h0041182A, 32'h00000001};  // slt -1<5
        vecs[6] = '{32'h20030007, 32'h20430001, 32'h00000000};  // addi wrap
        vecs[7] = '{32'h20000001, 32'h00011820, 32'h00000005};  // $0 stays 0
        vecs[8] = '{NOP_I,        32'h2023FFFA, 32'hFFFFFFFF};  // addi neg
        for (int v = 0; v < 9; v++) begin
            prog_q = '{32'h20010005, 32'h2002FFFF, vecs[v].i0, vecs[v].i1,
                       32'hAC030400, HALT_I};
            expect_store(32'h00000400, vecs[v].exp);
            run_prog($sformatf("alu%0d", v), 1'b0);
        end

        // ---------------- internal sw/lw, external lw ----------------
        prog_q = '{32'h20010007, 32'hAC010200, 32'h8C020200, 32'hAC020400,
                   32'h20030009, 32'h8C030400, 32'hAC030404, HALT_I};
        expect_store(32'h00000400, 32'h00000007);
        expect_store(32'h00000404, 32'h00000000);
        run_prog("mem", 1'b0);

        // ---------------- branches and jump ----------------
        prog_q = '{32'h20010003, 32'h10210001, 32'h20020009, 32'hAC020400,
                   32'h10200001, 32'h20040008, 32'hAC040404, 32'h08000009,
                   HALT_I,       32'h20A50001, 32'hAC050408, 32'h10A10001,
                   32'h1000FFFC, HALT_I};
        expect_store(32'h00000400, 32'h00000000);
        expect_store(32'h00000404, 32'h00000008);
        expect_store(32'h00000408, 32'h00000001);
        expect_store(32'h00000408, 32'h00000002);
        expect_store(32'h00000408, 32'h00000003);
        run_prog("br", 1'b0);

        // ---------------- undefined opcode / funct halts ----------------
        prog_q = '{HALT_I, 32'hAC000400};
        run_prog("halt_op", 1'b0);
        check("halt_op_req", 32'(bus_req), 32'h0);
        prog_q = '{32'h00000007, 32'hAC000400};
        run_prog("halt_fn", 1'b0);
        check("halt_fn_req", 32'(bus_req), 32'h0);

        // ---------------- slave burst boundaries ----------------
        do_reset();
        prog_q = '{32'h20010011, 32'hAC010400, HALT_I, HALT_I};
        load_prog();
        // single-cycle bursts only latch an address
        @(negedge clk); bus_ack = 1'b1; bus_ctrl_in = CMD_WRITE; bus_data_in = 32'h1;
        @(negedge clk); bus_ack = 1'b0; bus_ctrl_in = CMD_NONE;  bus_data_in = '0;
        @(negedge clk); bus_ack = 1'b1; bus_ctrl_in = CMD_WRITE; bus_data_in = HALT_I;
        @(negedge clk); bus_ack = 1'b0; bus_ctrl_in = CMD_NONE;  bus_data_in = '0;
        // four-cycle burst writes exactly mem[2]
        @(negedge clk); bus_ack = 1'b1; bus_ctrl_in = CMD_WRITE; bus_data_in = 32'h2;
        @(negedge clk); bus_data_in = 32'hAC010404;
        @(negedge clk); bus_data_in = HALT_I;
        @(negedge clk); bus_data_in = HALT_I;
        @(negedge clk); bus_ack = 1'b0; bus_ctrl_in = CMD_NONE;  bus_data_in = '0;
        expect_store(32'h00000400, 32'h00000011);
        expect_store(32'h00000404, 32'h00000011);
        run_cmd();
        serve("burst", 300, 1'b0);

        // ---------------- reset during XSTORE ----------------
        do_reset();
        prog_q = '{32'h20010022, 32'hAC010400, HALT_I};
        load_prog();
        run_cmd();
        waited = 0;
        while (bus_req !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("xrst_req_seen", 32'(bus_req), 32'h1);
        bus_ack = 1'b1;
        @(negedge clk);
        check("xrst_ctrl_mid", 32'(bus_ctrl_out), 32'(CMD_WRITE));
        #2 reset_ext = 1'b0;
        #1;
        check("xrst_req_async", 32'(bus_req), 32'h0);
        check("xrst_ctrl_async", 32'(bus_ctrl_out), 32'(CMD_NONE));
        check("xrst_data_async", bus_data_out, 32'h0);
        bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset_ext = 1'b1;
        @(negedge clk);
        // program must still be in memory
        expect_store(32'h00000400, 32'h00000022);
        run_cmd();
        serve("retain", 300, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_cpu.md
Name: mips_cpu

Overview:
- Small multicycle MIPS-subset processor with a 256-word internal unified memory, attached to the shared system bus.
- After reset it acts as a bus slave: a bus master loads a program into the internal memory, then issues a run command.
- While running, stores to addresses beyond internal memory go out over the bus as a bus-master write using a req/ack handshake.

Parameters:
- BUS_WIDTH, 32, data bus width; also the instruction and register width.
- CTRL_WIDTH, 8, bus control/command width.
- MEM_WORDS, 256, depth of the internal word-addressed memory.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_ext  in  1  asynchronous, active-low reset.
- bus_ctrl_in  in  CTRL_WIDTH  command from the current bus master.
- bus_ack  in  1  bus qualifier: slave-mode "transfer valid", master-mode "grant".
- bus_data_in  in  BUS_WIDTH  bus data into the CPU.
- bus_req  out  1  request for bus mastership.
- bus_ctrl_out  out  CTRL_WIDTH  command driven by the CPU when it is master.
- bus_data_out  out  BUS_WIDTH  bus data out of the CPU.

Behaviour:
- Commands: NONE=8'hFF, WRITE=8'hFE, RUN=8'hFD.
- Reset (reset_ext=0, asynchronous) sets:
  - PC=0; all 32 registers=0;
  - FSM=SLAVE; slave phase=ADDR;
  - bus_req=0, bus_ctrl_out=NONE, bus_data_out=0.
  - Internal memory contents are not reset.
- SLAVE state, evaluated each cycle:
  - bus_ack=0: phase returns to ADDR.
  - bus_ack=1 and bus_ctrl_in=WRITE, phase ADDR: latch bus_data_in[7:0] as the word address, phase becomes DATA.
  - bus_ack=1 and bus_ctrl_in=WRITE, phase DATA: mem[addr] <= bus_data_in, phase becomes DONE.
  - Phase DONE: further ack cycles are ignored until bus_ack drops.
  - Result: one word is written per ack burst of 2 or more cycles.
  - bus_ack=1 and bus_ctrl_in=RUN: go to FETCH with PC=0.
- Execution FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
  - FETCH: IR <= mem[PC[9:2]].
  - DECODE: read rs/rt; sign-extend imm16.
  - Register $0 always reads 0; writes to $0 are discarded.
- Supported instructions; any other opcode/funct goes to HALT:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A. Write rd, PC+4.
  - addi (0x08): rt <= rs + sext(imm). Arithmetic wraps; no overflow trap.
  - lw (0x23): address = rs + sext(imm).
    - Word index < MEM_WORDS: rt <= mem[addr>>2].
    - Otherwise: rt <= 0.
  - sw (0x2B): address = rs + sext(imm).
    - Word index < MEM_WORDS: internal write.
    - Otherwise: external store (below).
  - beq (0x04): if rs==rt, PC <= PC+4+(sext<<2); else PC+4.
  - j (0x02): PC <= {PC[31:28], target, 2'b00}.
- External store (state XSTORE):
  - Assert bus_req=1 and hold it until the store completes.
  - On the first cycle with bus_ack=1: drive bus_ctrl_out=WRITE, bus_data_out = byte address.
  - Next cycle: bus_data_out = rt value.
  - Next cycle: bus_req=0, bus_ctrl_out=NONE, bus_data_out=0; PC+4; go to FETCH.
  - The CPU does not deassert the store if bus_ack drops mid-transfer.
- HALT: outputs idle; only reset exits.
- PC word index wraps modulo MEM_WORDS.
- Reset asserted mid-operation aborts immediately, including dropping bus_req; memory contents are retained.

Test Plan:
- Load program:
  - Cycles with ack=1, ctrl=FE, data 0 then 0x20080005 -> mem[0]=0x20080005.
  - Repeat the same sequence for address 1 = 0x201D1050 and address 2 = 0xAFA80000.
  - Then send ack with ctrl=FD.
  - Required: $t0=5, $sp=0x1050; bus_req rises in the sw cycle.
  - After ack: bus_ctrl_out=FE, bus_data_out=0x1050, next cycle 0x00000005; then bus_req=0.
- Internal sw/lw:
  - Program: addi $1,$0,7; sw $1,16($0); lw $2,16($0).
  - Required: $2=7; bus_req never asserts.
- Branch/jump:
  - beq taken skips one instruction; j loops.
  - Required: PC trace matches; a skipped addi leaves its register 0.
- ALU:
  - add/sub/and/or/slt with 5 and 0xFFFFFFFF.
  - Required: 4, 6, 5, 0xFFFFFFFF, slt=0; $0 stays 0 after addi $0,$0,1.
- Undefined opcode 0x3F -> HALT: bus_req=0, PC frozen.
- Slave and reset boundary cases:
  - Single-cycle ack burst writes nothing.
  - Ack held 4 cycles writes exactly one word.
  - Reset during XSTORE drops bus_req asynchronously; memory is retained.
